// File: rtl/sisc_defs.sv
// Shared SISC definitions: controller state encodings, opcodes and ALU operand-select codes.
package sisc_defs;

   localparam logic [2:0] ST_START0    = 3'd0;
   localparam logic [2:0] ST_START1    = 3'd1;
   localparam logic [2:0] ST_FETCH     = 3'd2;
   localparam logic [2:0] ST_DECODE    = 3'd3;
   localparam logic [2:0] ST_EXECUTE   = 3'd4;
   localparam logic [2:0] ST_MEM       = 3'd5;
   localparam logic [2:0] ST_WRITEBACK = 3'd6;
   localparam logic [2:0] ST_HALT      = 3'd7;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_BRA = 4'h2;
   localparam logic [3:0] OP_BRR = 4'h3;
   localparam logic [3:0] OP_ALU = 4'h8;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [1:0] ALU_RR = 2'b00;
   localparam logic [1:0] ALU_RI = 2'b01;

   function automatic logic op_defined(input logic [3:0] op);
      return (op == OP_NOP) || (op == OP_BRA) || (op == OP_BRR) ||
             (op == OP_ALU) || (op == OP_HLT);
   endfunction

endpackage

// File: rtl/ctrl_unit_if.sv
// Instruction-field / status inputs and datapath control strobes between controller and datapath.
interface ctrl_unit_if;

   logic [3:0] opcode;
   logic [3:0] mm;
   logic [3:0] stat;
   logic       ir_load;
   logic       pc_write;
   logic       pc_sel;
   logic       br_sel;
   logic [1:0] alu_op;
   logic       stat_en;
   logic       rf_we;
   logic       wb_sel;
   logic       halted;

   modport master (
      input  opcode, mm, stat,
      output ir_load, pc_write, pc_sel, br_sel, alu_op, stat_en, rf_we, wb_sel, halted
   );

   modport slave (
      output opcode, mm, stat,
      input  ir_load, pc_write, pc_sel, br_sel, alu_op, stat_en, rf_we, wb_sel, halted
   );

endinterface

// File: rtl/ctrl_unit.sv
// SISC multicycle controller: one state register, combinational next-state and Moore/Mealy control decode.
module ctrl_unit
   import sisc_defs::*;
#(
   parameter bit HALT_ON_ILLEGAL = 1'b0
) (
   input  logic         clk,
   input  logic         rst_f,
   ctrl_unit_if.master  bus
);

   logic [2:0] state_q;
   logic [2:0] state_d;

   logic       ir_load;
   logic       pc_write;
   logic       pc_sel;
   logic       br_sel;
   logic [1:0] alu_op;
   logic       stat_en;
   logic       rf_we;
   logic       wb_sel;
   logic       halted;

   logic       is_alu;
   logic       is_branch;
   logic [1:0] alu_code;

   // An empty condition mask means "branch always".
   function automatic logic br_taken(input logic [3:0] mask, input logic [3:0] flags);
      return (mask == 4'b0000) || ((mask & flags) != 4'b0000);
   endfunction

   assign is_alu    = (bus.opcode == OP_ALU);
   assign is_branch = (bus.opcode == OP_BRA) || (bus.opcode == OP_BRR);
   assign alu_code  = bus.mm[3] ? ALU_RI : ALU_RR;

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) state_q <= ST_START0;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_START0:    state_d = ST_START1;
         ST_START1:    state_d = ST_FETCH;
         ST_FETCH:     state_d = ST_DECODE;
         ST_DECODE: begin
            if ((bus.opcode == OP_HLT) || (HALT_ON_ILLEGAL && !op_defined(bus.opcode)))
               state_d = ST_HALT;
            else
               state_d = ST_EXECUTE;
         end
         ST_EXECUTE:   state_d = ST_MEM;
         ST_MEM:       state_d = ST_WRITEBACK;
         ST_WRITEBACK: state_d = ST_FETCH;
         ST_HALT:      state_d = ST_HALT;
         default:      state_d = ST_START0;
      endcase
   end

   // Outputs are forced low while reset is asserted so nothing leaks during the reset edge.
   always_comb begin
      ir_load  = 1'b0;
      pc_write = 1'b0;
      pc_sel   = 1'b0;
      br_sel   = 1'b0;
      alu_op   = ALU_RR;
      stat_en  = 1'b0;
      rf_we    = 1'b0;
      wb_sel   = 1'b0;
      halted   = 1'b0;
      if (rst_f) begin
         case (state_q)
            ST_FETCH: begin
               ir_load  = 1'b1;
               pc_write = 1'b1;
            end
            ST_EXECUTE: begin
               if (is_alu) begin
                  alu_op  = alu_code;
                  stat_en = 1'b1;
               end
               if (is_branch && br_taken(bus.mm, bus.stat)) begin
                  pc_write = 1'b1;
                  pc_sel   = 1'b1;
                  br_sel   = (bus.opcode == OP_BRR);
               end
            end
            ST_MEM: begin
               if (is_alu) alu_op = alu_code;
            end
            ST_WRITEBACK: begin
               if (is_alu) begin
                  alu_op = alu_code;
                  rf_we  = 1'b1;
               end
            end
            ST_HALT:  halted = 1'b1;
            default: ;
         endcase
      end
   end

   assign bus.ir_load  = ir_load;
   assign bus.pc_write = pc_write;
   assign bus.pc_sel   = pc_sel;
   assign bus.br_sel   = br_sel;
   assign bus.alu_op   = alu_op;
   assign bus.stat_en  = stat_en;
   assign bus.rf_we    = rf_we;
   assign bus.wb_sel   = wb_sel;
   assign bus.halted   = halted;

endmodule

// File: tb/tb_ctrl_unit.sv
// Directed-vector bench for ctrl_unit; one instance per HALT_ON_ILLEGAL setting, shared stimulus.
module tb_ctrl_unit;
   import sisc_defs::*;

   // Output vector: {ir_load, pc_write, pc_sel, br_sel, alu_op[1:0], stat_en, rf_we, wb_sel, halted}
   localparam logic [9:0] O_NONE  = 10'h000;
   localparam logic [9:0] O_FETCH = 10'h300;
   localparam logic [9:0] O_HALT  = 10'h001;
   localparam logic [9:0] O_BRR   = 10'h1C0;
   localparam logic [9:0] O_BRA   = 10'h180;
   localparam logic [9:0] O_EX_RI = 10'h018;
   localparam logic [9:0] O_ME_RI = 10'h010;
   localparam logic [9:0] O_WB_RI = 10'h014;
   localparam logic [9:0] O_EX_RR = 10'h008;
   localparam logic [9:0] O_WB_RR = 10'h004;

   logic clk;
   logic rst_f;
   int   n_cmp;
   int   n_err;

   ctrl_unit_if bus0 ();
   ctrl_unit_if bus1 ();

   ctrl_unit #(.HALT_ON_ILLEGAL(1'b0)) dut0 (.clk(clk), .rst_f(rst_f), .bus(bus0));
   ctrl_unit #(.HALT_ON_ILLEGAL(1'b1)) dut1 (.clk(clk), .rst_f(rst_f), .bus(bus1));

   logic [9:0] o0;
   logic [9:0] o1;
   assign o0 = {bus0.ir_load, bus0.pc_write, bus0.pc_sel, bus0.br_sel, bus0.alu_op,
                bus0.stat_en, bus0.rf_we, bus0.wb_sel, bus0.halted};
   assign o1 = {bus1.ir_load, bus1.pc_write, bus1.pc_sel, bus1.br_sel, bus1.alu_op,
                bus1.stat_en, bus1.rf_we, bus1.wb_sel, bus1.halted};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_in(input logic [3:0] op, input logic [3:0] m, input logic [3:0] st);
      bus0.opcode = op; bus0.mm = m; bus0.stat = st;
      bus1.opcode = op; bus1.mm = m; bus1.stat = st;
   endtask

   task automatic chk2(input string tag, input logic [9:0] exp);
      chk({tag, "/d0"}, o0, exp);
      chk({tag, "/d1"}, o1, exp);
   endtask

   // Called at a negedge with rst_f just released: START1 then FETCH must follow.
   task automatic release_seq(input string tag);
      step();
      chk2({tag, ".start1"}, O_NONE);
      step();
      chk2({tag, ".fetch"}, O_FETCH);
   endtask

   // Called at a negedge while in FETCH; returns at the next FETCH.
   task automatic run_instr(input string tag, input logic [3:0] op, input logic [3:0] m,
                            input logic [3:0] st, input logic [9:0] e_ex,
                            input logic [9:0] e_me, input logic [9:0] e_wb);
      set_in(op, m, st);
      chk2({tag, ".fetch"}, O_FETCH);
      step(); chk2({tag, ".decode"}, O_NONE);
      step(); chk2({tag, ".exec"}, e_ex);
      step(); chk2({tag, ".mem"}, e_me);
      step(); chk2({tag, ".wb"}, e_wb);
      step();
   endtask

   task automatic reset_pulse(input string tag);
      #2 rst_f = 1'b0;
      #1 chk2({tag, ".async"}, O_NONE);
      @(negedge clk);
      chk2({tag, ".held"}, O_NONE);
      rst_f = 1'b1;
      release_seq(tag);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_f = 1'b0;
      set_in(OP_NOP, 4'h0, 4'h0);

      @(negedge clk);
      chk2("reset", O_NONE);
      @(negedge clk);
      rst_f = 1'b1;
      release_seq("boot");

      run_instr("nop0", OP_NOP, 4'h0, 4'h0, O_NONE, O_NONE, O_NONE);
      run_instr("nop1", OP_NOP, 4'h0, 4'h0, O_NONE, O_NONE, O_NONE);

      run_instr("adi",  OP_ALU, 4'h8, 4'h0, O_EX_RI, O_ME_RI, O_WB_RI);
      run_instr("add",  OP_ALU, 4'h0, 4'h0, O_EX_RR, O_NONE,  O_WB_RR);

      run_instr("brr_t",  OP_BRR, 4'h1, 4'b0001, O_BRR,  O_NONE, O_NONE);
      run_instr("brr_nt", OP_BRR, 4'h1, 4'b1010, O_NONE, O_NONE, O_NONE);
      run_instr("bra_al", OP_BRA, 4'h0, 4'h0,    O_BRA,  O_NONE, O_NONE);
      run_instr("bra_n",  OP_BRA, 4'h2, 4'b0010, O_BRA,  O_NONE, O_NONE);
      run_instr("bra_nt", OP_BRA, 4'h4, 4'b1011, O_NONE, O_NONE, O_NONE);

      // Reset dropped while an ALU instruction sits in EXECUTE.
      set_in(OP_ALU, 4'h8, 4'h0);
      chk2("midrst.fetch", O_FETCH);
      step(); chk2("midrst.decode", O_NONE);
      step(); chk2("midrst.exec", O_EX_RI);
      reset_pulse("midrst");
      run_instr("after_midrst", OP_ALU, 4'h8, 4'h0, O_EX_RI, O_ME_RI, O_WB_RI);

      // Undefined opcode: NOP timing in dut0, HALT in dut1.
      set_in(4'h5, 4'h0, 4'h0);
      chk2("ill.fetch", O_FETCH);
      step(); chk2("ill.decode", O_NONE);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("ill.nop/d0", o0, O_NONE);
         chk("ill.halt/d1", o1, O_HALT);
      end
      step();
      chk("ill.refetch/d0", o0, O_FETCH);
      chk("ill.stay/d1", o1, O_HALT);
      set_in(OP_NOP, 4'h0, 4'h0);
      reset_pulse("illrst");

      // HLT: halted held regardless of later inputs, left only by reset.
      set_in(OP_HLT, 4'h0, 4'h0);
      chk2("hlt.fetch", O_FETCH);
      step(); chk2("hlt.decode", O_NONE);
      for (int i = 0; i < 20; i++) begin
         step();
         chk2("hlt.hold", O_HALT);
         if (i == 5) set_in(OP_ALU, 4'h8, 4'hF);
      end
      set_in(OP_NOP, 4'h0, 4'h0);
      reset_pulse("hltrst");
      run_instr("final", OP_BRR, 4'h0, 4'h0, O_BRR, O_NONE, O_NONE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
